d_mem_bus_controller: RTL and testbench

Parametrised successor to the data-memory interface. It decodes a core data request into one of NUM_SLAVES memory-mapped regions (BSRAM, frame buffer, mm_reg, UART, interrupt unit, ...) and drives a per-slave req/ack handshake. Unlike the previous interface, it has real ready/valid flow control, variable slave latency, a timeout, and an error response for unmapped addresses. It sits between the core's memory stage and the peripheral slaves.

---
 rtl/d_mem_bus_controller.sv | 162 ++++++++++++++++
 tb/tb_d_mem_bus_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_bus_controller.sv
// ============================================================================
//  Module   : d_mem_bus_controller
//  Purpose  : Decodes core data requests onto NUM_SLAVES memory-mapped slaves
//             with req/ack handshake, ready/valid flow control and timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module d_mem_bus_controller #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*ADDRESS_BITS-1:0] SLAVE_BASE =
    {32'h90000010, 32'h90000000, 32'h80000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDRESS_BITS-1:0] SLAVE_MASK =
    {32'hFFFFFFC0, 32'hFFFFFFF0, 32'hFFE00000, 32'hFFFFF000},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             read,
  input  logic                             write,
  input  logic [ADDRESS_BITS-1:0]          address,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             ready,
  output logic                             valid,
  output logic [ADDRESS_BITS-1:0]          out_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             error,
  output logic [NUM_SLAVES-1:0]            s_req,
  output logic                             s_we,
  output logic [ADDRESS_BITS-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  input  logic                             report
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [NUM_SLAVES-1:0] w_hit;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                 w_mapped;
  logic                 w_ack;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                 w_unused;

  // Base bits below the mask are don't-care, so a base need not be mask-aligned.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
    assign w_hit[gi] =
      (address & SLAVE_MASK[gi*ADDRESS_BITS +: ADDRESS_BITS]) ==
      (SLAVE_BASE[gi*ADDRESS_BITS +: ADDRESS_BITS] &
       SLAVE_MASK[gi*ADDRESS_BITS +: ADDRESS_BITS]);
  end

  always_comb begin
    w_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  assign w_mapped = |w_hit;
  assign w_ack    = |(s_ack & s_req);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_req[i]) begin
        w_rdata = w_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_unused = ^{report, 32'(CORE)};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      ready    <= 1'b0;
      valid    <= 1'b0;
      error    <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      s_req    <= '0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          if ((read | write) && ready) begin
            ready   <= 1'b0;
            s_addr  <= address;
            s_wdata <= in_data;
            s_we    <= write;
            if ((read & write) || !w_mapped) begin
              r_state  <= S_RESPOND;
              valid    <= 1'b1;
              error    <= 1'b1;
              out_data <= '0;
              out_addr <= address;
            end else begin
              r_state <= S_ACCESS;
              s_req   <= w_sel;
              r_count <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (w_ack) begin
            r_state  <= S_RESPOND;
            s_req    <= '0;
            valid    <= 1'b1;
            error    <= 1'b0;
            out_data <= s_we ? '0 : w_rdata;
            out_addr <= s_addr;
          end else if (r_count == c_CNT_LAST) begin
            r_state  <= S_RESPOND;
            s_req    <= '0;
            valid    <= 1'b1;
            error    <= 1'b1;
            out_data <= '0;
            out_addr <= s_addr;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
          ready   <= 1'b0;
          s_req   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_d_mem_bus_controller.sv
// ============================================================================
//  Module   : tb_d_mem_bus_controller
//  Purpose  : Directed self-checking bench for d_mem_bus_controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_d_mem_bus_controller;

  logic         clock;
  logic         reset;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  in_data;
  logic         ready;
  logic         valid;
  logic [31:0]  out_addr;
  logic [31:0]  out_data;
  logic         error;
  logic [3:0]   s_req;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;
  logic         report;

  int n_checks = 0;
  int n_pass   = 0;

  d_mem_bus_controller dut (
    .clock    (clock),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .in_data  (in_data),
    .ready    (ready),
    .valid    (valid),
    .out_addr (out_addr),
    .out_data (out_data),
    .error    (error),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ack    (s_ack),
    .report   (report)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, then consume the accept edge.
  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int budget;
    read    = r;
    write   = w;
    address = a;
    in_data = d;
    budget  = 0;
    while (!ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!ready) check("ready_wait", {63'd0, ready}, 64'd1);
    tick();
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    logic seen;
    reset   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    address = '0;
    in_data = '0;
    s_rdata = '0;
    s_ack   = '0;
    report  = 1'b0;

    tick();
    tick();
    check("rst_ready",    {63'd0, ready},    64'd0);
    check("rst_valid",    {63'd0, valid},    64'd0);
    check("rst_sreq",     {60'd0, s_req},    64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_addr", {32'd0, out_addr}, 64'd0);
    check("rst_s_addr",   {32'd0, s_addr},   64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", {63'd0, ready}, 64'd1);

    // Read slave0, ack in first ACCESS cycle
    s_rdata[31:0] = 32'hDEADBEEF;
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check("rd0_sreq",  {60'd0, s_req}, 64'h1);
    check("rd0_ready", {63'd0, ready}, 64'd0);
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0000;
    check("rd0_valid", {63'd0, valid},    64'd1);
    check("rd0_data",  {32'd0, out_data}, 64'hDEADBEEF);
    check("rd0_addr",  {32'd0, out_addr}, 64'h10);
    check("rd0_err",   {63'd0, error},    64'd0);
    check("rd0_sdrop", {60'd0, s_req},    64'd0);
    tick();
    check("rd0_vdrop", {63'd0, valid}, 64'd0);
    check("rd0_ready_back", {63'd0, ready}, 64'd1);

    // Write slave1, ack after 3 wait cycles
    s_rdata[63:32] = 32'h1234_5678;
    issue(1'b0, 1'b1, 32'h8000_0004, 32'h5);
    for (int k = 0; k < 3; k++) begin
      check("wr1_sreq",  {60'd0, s_req},   64'h2);
      check("wr1_we",    {63'd0, s_we},    64'd1);
      check("wr1_wdata", {32'd0, s_wdata}, 64'h5);
      tick();
    end
    check("wr1_sreq4", {60'd0, s_req}, 64'h2);
    check("wr1_novalid", {63'd0, valid}, 64'd0);
    s_ack = 4'b0010;
    tick();
    s_ack = 4'b0000;
    check("wr1_valid", {63'd0, valid},    64'd1);
    check("wr1_data",  {32'd0, out_data}, 64'h0);
    check("wr1_err",   {63'd0, error},    64'd0);
    check("wr1_addr",  {32'd0, out_addr}, 64'h8000_0004);
    tick();

    // Decode boundaries between slave2 and slave3
    s_rdata[127:96] = 32'hA5A5_0003;
    issue(1'b1, 1'b0, 32'h9000_0014, 32'h0);
    check("dec3_sreq", {60'd0, s_req}, 64'h8);
    s_ack = 4'b1000;
    tick();
    s_ack = 4'b0000;
    check("dec3_data", {32'd0, out_data}, 64'hA5A5_0003);
    tick();
    issue(1'b1, 1'b0, 32'h9000_0004, 32'h0);
    check("dec2_sreq", {60'd0, s_req}, 64'h4);
    s_ack = 4'b0100;
    tick();
    s_ack = 4'b0000;
    tick();

    // Unmapped and read&write errors
    issue(1'b1, 1'b0, 32'h4000_0000, 32'h0);
    check("unm_valid", {63'd0, valid},    64'd1);
    check("unm_err",   {63'd0, error},    64'd1);
    check("unm_data",  {32'd0, out_data}, 64'h0);
    check("unm_sreq",  {60'd0, s_req},    64'h0);
    check("unm_addr",  {32'd0, out_addr}, 64'h4000_0000);
    tick();
    check("unm_vdrop", {63'd0, valid}, 64'd0);
    issue(1'b1, 1'b1, 32'h0000_0010, 32'h7);
    check("rw_valid", {63'd0, valid}, 64'd1);
    check("rw_err",   {63'd0, error}, 64'd1);
    check("rw_sreq",  {60'd0, s_req}, 64'h0);
    tick();

    // Timeout: slave2 never acks
    issue(1'b1, 1'b0, 32'h9000_0000, 32'h0);
    for (int k = 0; k < 15; k++) tick();
    check("to_sreq16",  {60'd0, s_req}, 64'h4);
    check("to_novalid", {63'd0, valid}, 64'd0);
    tick();
    check("to_valid", {63'd0, valid},    64'd1);
    check("to_err",   {63'd0, error},    64'd1);
    check("to_data",  {32'd0, out_data}, 64'h0);
    check("to_sdrop", {60'd0, s_req},    64'h0);
    tick();

    // Ack in cycle 16 beats the timeout
    s_rdata[95:64] = 32'hCAFE_F00D;
    issue(1'b1, 1'b0, 32'h9000_0000, 32'h0);
    for (int k = 0; k < 15; k++) tick();
    s_ack = 4'b0100;
    tick();
    s_ack = 4'b0000;
    check("ack16_valid", {63'd0, valid},    64'd1);
    check("ack16_err",   {63'd0, error},    64'd0);
    check("ack16_data",  {32'd0, out_data}, 64'hCAFE_F00D);
    tick();

    // Stray ack from a non-selected slave
    s_rdata[127:96] = 32'h0000_0BAD;
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    s_ack = 4'b1000;
    tick();
    check("stray_novalid", {63'd0, valid}, 64'd0);
    check("stray_sreq",    {60'd0, s_req}, 64'h1);
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0000;
    check("stray_data", {32'd0, out_data}, 64'hDEADBEEF);
    tick();

    // Reset during ACCESS aborts silently
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_sreq",  {60'd0, s_req}, 64'h0);
    check("abort_ready", {63'd0, ready}, 64'd0);
    seen  = valid;
    s_ack = 4'b0001;
    tick();
    check("abort_ready_back", {63'd0, ready}, 64'd1);
    for (int k = 0; k < 20; k++) begin
      seen = seen | valid;
      tick();
    end
    s_ack = 4'b0000;
    check("abort_no_valid", {63'd0, seen}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
